id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
Decode-to-execute pipeline stage of the pipelined RV32I core. It produces everything the execute-stage ALU consumes: registered ALUControlE, forwarded SrcAE/SrcBE and WriteDataE. It owns the ID/EX register, RAW forwarding selection, load-use stall detection with bubble insertion, branch flush and external hold.

Parameters:
XLEN, 32, datapath width
REGW, 5, register index width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
HoldE  in  1  freeze ID/EX register (memory stall)
FlushE  in  1  taken branch/jump: kill instruction entering E
CtrlD  in  10  ctrl_t: RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUControl[2:0], ALUSrc
ValidD  in  1  decode slot holds a real instruction
RD1D, RD2D  in  XLEN  register file read data
ImmExtD, PCD, PCPlus4D  in  XLEN  immediate, PC, PC+4
Rs1D, Rs2D, RdD  in  REGW  register indices
ALUResultM  in  XLEN  M-stage forwarding source
RdM  in  REGW;  RegWriteM  in  1
ResultW  in  XLEN  W-stage forwarding source
RdW  in  REGW;  RegWriteW  in  1
LwStallD  out  1  load-use hazard: upstream must hold F and D
CtrlE  out  10  registered ctrl_t (ALUControlE = CtrlE.ALUControl)
ValidE  out  1  E slot holds a real instruction
SrcAE, SrcBE, WriteDataE  out  XLEN  ALU operands, store data
PCE, PCPlus4E, ImmExtE  out  XLEN  registered
Rs1E, Rs2E, RdE  out  REGW  registered
ForwardAE, ForwardBE  out  2  fwd_sel_t currently applied

Behaviour:
- Next-state priority at each edge: rst_n=0 > HoldE > (FlushE | LwStallD | !ValidD) bubble > load from D.
- Reset/bubble: every registered field 0 (CtrlE=0, ValidE=0, RdE=0, data=0) = ADD x0,x0 nop. All outputs 0 after reset (SrcBE=0, forwards=00).
- Hold: register unchanged; FlushE and LwStallD ignored that edge (upstream re-asserts flush).
- Latency: D inputs appear on E outputs 1 cycle after the loading edge.
- Forwarding (combinational on E regs and M/W inputs): ForwardAE=10 if RegWriteM & RdM!=0 & RdM==Rs1E; else 01 if RegWriteW & RdW!=0 & RdW==Rs1E; else 00. ForwardBE same using Rs2E. M beats W; x0 never forwarded.
- fwdA/fwdB = 00 -> RD1E/RD2E reg, 01 -> ResultW, 10 -> ALUResultM; 11 unused, treated as 00.
- SrcAE=fwdA; WriteDataE=fwdB; SrcBE = CtrlE.ALUSrc ? ImmExtE : fwdB.
- LwStallD = ValidE & CtrlE.ResultSrc==01 (load) & RdE!=0 & (RdE==Rs1D | RdE==Rs2D); combinational, asserted even during HoldE.
- Load-use: consumer stays in D (held upstream), E gets one bubble, consumer loads on following edge with W forwarding available.
- ValidD=0 loads a bubble regardless of other CtrlD bits.

Decomposition:
- Package riscv_pkg: ctrl_t packed struct (field order as in CtrlD); alu_op_t (ADD 000, SUB 001, AND 010, OR 011, SLL 100, SLT 101, RSV 110, LUI 111); result_src_t (ALU 00, MEM 01, PC4 10); fwd_sel_t (REG 00, WB 01, MEM 10); BUBBLE constant.
- Sub-module forward_unit: pure combinational source select for one operand, instantiated twice.

Test Plan:
- rst_n low 2 cycles with D inputs toggling -> all outputs 0, LwStallD=0; release -> first load visible next cycle.
- RD1D=5, RD2D=7, ALUSrcD=0, ALUControl=001, ValidD=1 -> next cycle SrcAE=5, SrcBE=7, ALUControlE=001; ALUSrc=1, ImmExtD=0x800 -> SrcBE=0x800, WriteDataE=7.
- Rs1E=3, RdM=3/RegWriteM=1/ALUResultM=0x10, RdW=3/RegWriteW=1/ResultW=0x20 -> SrcAE=0x10, ForwardAE=10; RdM=0 -> SrcAE=0x20, ForwardAE=01; RdW=0 too -> RD1E.
- E holds load RdE=5, D has Rs2D=5 -> LwStallD=1 same cycle; next cycle ValidE=0, RdE=0, CtrlE=0; with RdE=0 -> LwStallD=0.
- FlushE=1 with valid D -> next cycle bubble; FlushE=1 and HoldE=1 together -> all E outputs unchanged.
- rst_n=0 while HoldE=1 mid-operation -> all fields cleared at that edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared types for the RV32I pipeline decode/execute boundary.
//   ctrl_t       : decoded control bundle that travels down the pipe. Field
//                  order matches the CtrlD bit layout, MSB first.
//   alu_op_t     : ALU operation encoding carried in ctrl_t.ALUControl
//   result_src_t : write-back source select (ALU, data memory, PC+4)
//   fwd_sel_t    : operand source select produced by the forwarding logic
//   BUBBLE       : all-zero control word, which decodes as ADD x0,x0 (a nop)
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN_DEF = 32;
    localparam int REGW_DEF = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLL = 3'b100,
        ALU_SLT = 3'b101,
        ALU_RSV = 3'b110,
        ALU_LUI = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    // Encoding 2'b11 is never produced; consumers treat it like FWD_REG.
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic        RegWrite;
        result_src_t ResultSrc;
        logic        MemWrite;
        logic        Jump;
        logic        Branch;
        alu_op_t     ALUControl;
        logic        ALUSrc;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    // A load is the only instruction whose result is not available for
    // forwarding from the M stage.
    function automatic logic is_load(input ctrl_t c);
        return c.ResultSrc == RES_MEM;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_stage_if
// Bundle of every signal crossing the ID/EX stage boundary.
//   D-side inputs   : HoldE, FlushE, CtrlD, ValidD, RD1D, RD2D, ImmExtD, PCD,
//                     PCPlus4D, Rs1D, Rs2D, RdD
//   Forward sources : ALUResultM, RdM, RegWriteM, ResultW, RdW, RegWriteW
//   Stage outputs   : LwStallD, CtrlE, ValidE, SrcAE, SrcBE, WriteDataE, PCE,
//                     PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE, ForwardAE, ForwardBE
// Modports:
//   slave  : the stage itself
//   master : the surrounding pipeline (decode, hazard control, M/W stages)
// -----------------------------------------------------------------------------
interface id_ex_stage_if
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int REGW = REGW_DEF
);

    // Decode-side inputs
    logic            HoldE;
    logic            FlushE;
    ctrl_t           CtrlD;
    logic            ValidD;
    logic [XLEN-1:0] RD1D;
    logic [XLEN-1:0] RD2D;
    logic [XLEN-1:0] ImmExtD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;
    logic [REGW-1:0] Rs1D;
    logic [REGW-1:0] Rs2D;
    logic [REGW-1:0] RdD;

    // Forwarding sources from later stages
    logic [XLEN-1:0] ALUResultM;
    logic [REGW-1:0] RdM;
    logic            RegWriteM;
    logic [XLEN-1:0] ResultW;
    logic [REGW-1:0] RdW;
    logic            RegWriteW;

    // Stage outputs
    logic            LwStallD;
    ctrl_t           CtrlE;
    logic            ValidE;
    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic [XLEN-1:0] WriteDataE;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCPlus4E;
    logic [XLEN-1:0] ImmExtE;
    logic [REGW-1:0] Rs1E;
    logic [REGW-1:0] Rs2E;
    logic [REGW-1:0] RdE;
    fwd_sel_t        ForwardAE;
    fwd_sel_t        ForwardBE;

    modport slave (
        input  HoldE, FlushE, CtrlD, ValidD, RD1D, RD2D, ImmExtD, PCD,
               PCPlus4D, Rs1D, Rs2D, RdD,
               ALUResultM, RdM, RegWriteM, ResultW, RdW, RegWriteW,
        output LwStallD, CtrlE, ValidE, SrcAE, SrcBE, WriteDataE, PCE,
               PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE, ForwardAE, ForwardBE
    );

    modport master (
        output HoldE, FlushE, CtrlD, ValidD, RD1D, RD2D, ImmExtD, PCD,
               PCPlus4D, Rs1D, Rs2D, RdD,
               ALUResultM, RdM, RegWriteM, ResultW, RdW, RegWriteW,
        input  LwStallD, CtrlE, ValidE, SrcAE, SrcBE, WriteDataE, PCE,
               PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE, ForwardAE, ForwardBE
    );

endinterface

// File: rtl/id_ex_stage_forward_unit.sv
// -----------------------------------------------------------------------------
// forward_unit
// Combinational RAW-forwarding select for one execute-stage operand.
//   rs_e         : source register index held in the E stage
//   rd_m/reg_write_m, rd_w/reg_write_w : destinations of the M and W stages
//   reg_data     : operand value read from the register file in decode
//   alu_result_m : M-stage ALU result
//   result_w     : W-stage write-back value
//   sel          : chosen source (FWD_MEM beats FWD_WB beats FWD_REG)
//   operand      : the selected value
// -----------------------------------------------------------------------------
module forward_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int REGW = REGW_DEF
) (
    input  logic [REGW-1:0] rs_e,
    input  logic [REGW-1:0] rd_m,
    input  logic            reg_write_m,
    input  logic [REGW-1:0] rd_w,
    input  logic            reg_write_w,
    input  logic [XLEN-1:0] reg_data,
    input  logic [XLEN-1:0] alu_result_m,
    input  logic [XLEN-1:0] result_w,
    output fwd_sel_t        sel,
    output logic [XLEN-1:0] operand
);

    logic hit_m;
    logic hit_w;

    // x0 is hard-wired to zero, so a write to it must never be forwarded.
    assign hit_m = reg_write_m && (rd_m != '0) && (rd_m == rs_e);
    assign hit_w = reg_write_w && (rd_w != '0) && (rd_w == rs_e);

    // The M stage holds the younger result, so it wins over W.
    always_comb begin
        sel = FWD_REG;
        if (hit_m) begin
            sel = FWD_MEM;
        end else if (hit_w) begin
            sel = FWD_WB;
        end
    end

    always_comb begin
        case (sel)
            FWD_MEM: operand = alu_result_m;
            FWD_WB:  operand = result_w;
            default: operand = reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// Decode-to-execute boundary of the pipelined RV32I core. Holds the ID/EX
// register, detects load-use hazards, inserts bubbles on flush/stall/invalid
// decode, honours an external hold, and forwards M/W results into the ALU
// operands.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : id_ex_stage_if.slave carrying D inputs, forwarding sources and
//           all E-stage outputs
// Edge priority: reset > hold > bubble (flush | load-use | !ValidD) > load.
// -----------------------------------------------------------------------------
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int REGW = REGW_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);

    // ID/EX register
    ctrl_t           ctrl_reg, ctrl_next;
    logic            valid_reg, valid_next;
    logic [XLEN-1:0] rd1_reg, rd1_next;
    logic [XLEN-1:0] rd2_reg, rd2_next;
    logic [XLEN-1:0] imm_reg, imm_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] pc4_reg, pc4_next;
    logic [REGW-1:0] rs1_reg, rs1_next;
    logic [REGW-1:0] rs2_reg, rs2_next;
    logic [REGW-1:0] rd_reg, rd_next;

    logic lw_stall;
    logic insert_bubble;

    // Load-use hazard: the load in E cannot forward its data in time for the
    // instruction now in D. Purely combinational on the E register, so it is
    // still reported while the register is held.
    assign lw_stall = valid_reg && is_load(ctrl_reg) && (rd_reg != '0) &&
                      ((rd_reg == bus.Rs1D) || (rd_reg == bus.Rs2D));

    assign insert_bubble = bus.FlushE || lw_stall || !bus.ValidD;

    // Next-state: a bubble is the all-zero word (ADD x0,x0 nop), regardless
    // of whatever control bits decode happens to present.
    always_comb begin
        ctrl_next  = BUBBLE;
        valid_next = 1'b0;
        rd1_next   = '0;
        rd2_next   = '0;
        imm_next   = '0;
        pc_next    = '0;
        pc4_next   = '0;
        rs1_next   = '0;
        rs2_next   = '0;
        rd_next    = '0;
        if (!insert_bubble) begin
            ctrl_next  = bus.CtrlD;
            valid_next = 1'b1;
            rd1_next   = bus.RD1D;
            rd2_next   = bus.RD2D;
            imm_next   = bus.ImmExtD;
            pc_next    = bus.PCD;
            pc4_next   = bus.PCPlus4D;
            rs1_next   = bus.Rs1D;
            rs2_next   = bus.Rs2D;
            rd_next    = bus.RdD;
        end
    end

    // Hold freezes everything, including any pending flush or bubble; the
    // upstream logic keeps asserting flush until the hold drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_reg  <= BUBBLE;
            valid_reg <= 1'b0;
            rd1_reg   <= '0;
            rd2_reg   <= '0;
            imm_reg   <= '0;
            pc_reg    <= '0;
            pc4_reg   <= '0;
            rs1_reg   <= '0;
            rs2_reg   <= '0;
            rd_reg    <= '0;
        end else if (!bus.HoldE) begin
            ctrl_reg  <= ctrl_next;
            valid_reg <= valid_next;
            rd1_reg   <= rd1_next;
            rd2_reg   <= rd2_next;
            imm_reg   <= imm_next;
            pc_reg    <= pc_next;
            pc4_reg   <= pc4_next;
            rs1_reg   <= rs1_next;
            rs2_reg   <= rs2_next;
            rd_reg    <= rd_next;
        end
    end

    // Forwarding: operand 0 is SrcA (rs1), operand 1 is the rs2 path that
    // feeds both store data and, for register-register ops, SrcB.
    logic [REGW-1:0] rs_e      [2];
    logic [XLEN-1:0] reg_e     [2];
    fwd_sel_t        fwd_sel   [2];
    logic [XLEN-1:0] fwd_value [2];

    assign rs_e[0]  = rs1_reg;
    assign rs_e[1]  = rs2_reg;
    assign reg_e[0] = rd1_reg;
    assign reg_e[1] = rd2_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            forward_unit #(
                .XLEN (XLEN),
                .REGW (REGW)
            ) u_forward_unit (
                .rs_e         (rs_e[gi]),
                .rd_m         (bus.RdM),
                .reg_write_m  (bus.RegWriteM),
                .rd_w         (bus.RdW),
                .reg_write_w  (bus.RegWriteW),
                .reg_data     (reg_e[gi]),
                .alu_result_m (bus.ALUResultM),
                .result_w     (bus.ResultW),
                .sel          (fwd_sel[gi]),
                .operand      (fwd_value[gi])
            );
        end
    endgenerate

    assign bus.LwStallD   = lw_stall;
    assign bus.CtrlE      = ctrl_reg;
    assign bus.ValidE     = valid_reg;
    assign bus.SrcAE      = fwd_value[0];
    assign bus.WriteDataE = fwd_value[1];
    assign bus.SrcBE      = ctrl_reg.ALUSrc ? imm_reg : fwd_value[1];
    assign bus.PCE        = pc_reg;
    assign bus.PCPlus4E   = pc4_reg;
    assign bus.ImmExtE    = imm_reg;
    assign bus.Rs1E       = rs1_reg;
    assign bus.Rs2E       = rs2_reg;
    assign bus.RdE        = rd_reg;
    assign bus.ForwardAE  = fwd_sel[0];
    assign bus.ForwardBE  = fwd_sel[1];

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed steps followed by randomized traffic, all compared against an
// instruction-level model of what the E slot should contain.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Model of the instruction sitting in the E slot.
    typedef struct {
        logic [9:0]  ctrl;
        logic        valid;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rs1, rs2, rd;
    } e_slot_t;

    e_slot_t m;

    function automatic e_slot_t nop_slot();
        e_slot_t s;
        s.ctrl = '0; s.valid = 1'b0;
        s.rd1 = '0; s.rd2 = '0; s.imm = '0; s.pc = '0; s.pc4 = '0;
        s.rs1 = '0; s.rs2 = '0; s.rd = '0;
        return s;
    endfunction

    // Control word layout: RegWrite[9] ResultSrc[8:7] MemWrite[6] Jump[5]
    // Branch[4] ALUControl[3:1] ALUSrc[0]
    function automatic ctrl_t mk_ctrl(logic rw, logic [1:0] rsrc, logic [2:0] op, logic src);
        logic [9:0] w;
        w = {rw, rsrc, 1'b0, 1'b0, 1'b0, op, src};
        return ctrl_t'(w);
    endfunction

    // A load in E whose destination is read by the instruction in D.
    function automatic logic model_stall();
        return m.valid && (m.ctrl[8:7] == 2'b01) && (m.rd != 5'd0) &&
               ((m.rd == bus.Rs1D) || (m.rd == bus.Rs2D));
    endfunction

    function automatic logic [1:0] model_fwd(logic [4:0] rs);
        if (bus.RegWriteM && bus.RdM != 5'd0 && bus.RdM == rs) return 2'b10;
        if (bus.RegWriteW && bus.RdW != 5'd0 && bus.RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Let combinational outputs settle, then compare every output.
    task automatic check_all(string tag);
        logic [1:0]  fa, fb;
        logic [31:0] a, b;
        #1;
        fa = model_fwd(m.rs1);
        fb = model_fwd(m.rs2);
        a  = (fa == 2'b10) ? bus.ALUResultM : (fa == 2'b01) ? bus.ResultW : m.rd1;
        b  = (fb == 2'b10) ? bus.ALUResultM : (fb == 2'b01) ? bus.ResultW : m.rd2;
        chk({tag, "/ctrl"},   32'(bus.CtrlE),      32'(m.ctrl));
        chk({tag, "/valid"},  32'(bus.ValidE),     32'(m.valid));
        chk({tag, "/srca"},   bus.SrcAE,           a);
        chk({tag, "/srcb"},   bus.SrcBE,           m.ctrl[0] ? m.imm : b);
        chk({tag, "/wdata"},  bus.WriteDataE,      b);
        chk({tag, "/pc"},     bus.PCE,             m.pc);
        chk({tag, "/pc4"},    bus.PCPlus4E,        m.pc4);
        chk({tag, "/imm"},    bus.ImmExtE,         m.imm);
        chk({tag, "/rs1"},    32'(bus.Rs1E),       32'(m.rs1));
        chk({tag, "/rs2"},    32'(bus.Rs2E),       32'(m.rs2));
        chk({tag, "/rd"},     32'(bus.RdE),        32'(m.rd));
        chk({tag, "/fwda"},   32'(bus.ForwardAE),  32'(fa));
        chk({tag, "/fwdb"},   32'(bus.ForwardBE),  32'(fb));
        chk({tag, "/stall"},  32'(bus.LwStallD),   32'(model_stall()));
        $display("txn %-12s valid=%0d rd=%0d srca=%08h srcb=%08h stall=%0d",
                 tag, bus.ValidE, bus.RdE, bus.SrcAE, bus.SrcBE, bus.LwStallD);
    endtask

    // Advance one clock, updating the model from the inputs present at the edge.
    task automatic cycle();
        e_slot_t nxt;
        if (!rst_n) begin
            nxt = nop_slot();
        end else if (bus.HoldE) begin
            nxt = m;
        end else if (bus.FlushE || model_stall() || !bus.ValidD) begin
            nxt = nop_slot();
        end else begin
            nxt.ctrl  = bus.CtrlD;
            nxt.valid = 1'b1;
            nxt.rd1   = bus.RD1D;
            nxt.rd2   = bus.RD2D;
            nxt.imm   = bus.ImmExtD;
            nxt.pc    = bus.PCD;
            nxt.pc4   = bus.PCPlus4D;
            nxt.rs1   = bus.Rs1D;
            nxt.rs2   = bus.Rs2D;
            nxt.rd    = bus.RdD;
        end
        @(posedge clk);
        m = nxt;
        #1;
    endtask

    task automatic set_d(logic v, ctrl_t c, logic [31:0] r1, logic [31:0] r2,
                         logic [31:0] imm, logic [4:0] s1, logic [4:0] s2, logic [4:0] d);
        logic [31:0] pc;
        pc           = {$urandom_range(0, 32'h0fff_ffff), 2'b00} ;
        bus.ValidD   = v;
        bus.CtrlD    = c;
        bus.RD1D     = r1;
        bus.RD2D     = r2;
        bus.ImmExtD  = imm;
        bus.PCD      = pc;
        bus.PCPlus4D = pc + 32'd4;
        bus.Rs1D     = s1;
        bus.Rs2D     = s2;
        bus.RdD      = d;
    endtask

    task automatic rand_d();
        logic [9:0] cw;
        cw = 10'($urandom);
        set_d(($urandom_range(0, 7) != 0), ctrl_t'(cw), $urandom, $urandom, $urandom,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    endtask

    task automatic set_mw(logic wm, logic [4:0] dm, logic [31:0] am,
                          logic ww, logic [4:0] dw, logic [31:0] rw);
        bus.RegWriteM  = wm;
        bus.RdM        = dm;
        bus.ALUResultM = am;
        bus.RegWriteW  = ww;
        bus.RdW        = dw;
        bus.ResultW    = rw;
    endtask

    initial begin
        m          = nop_slot();
        rst_n      = 1'b0;
        bus.HoldE  = 1'b0;
        bus.FlushE = 1'b0;
        set_mw(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        rand_d();

        // Reset for two cycles while D toggles
        repeat (2) begin
            rand_d();
            cycle();
        end
        set_d(1'b1, mk_ctrl(1'b1, 2'b00, 3'b001, 1'b0), 32'd5, 32'd7, 32'h100, 5'd1, 5'd2, 5'd4);
        check_all("reset");
        chk("reset/srcb_zero", bus.SrcBE, 32'd0);
        chk("reset/stall_zero", 32'(bus.LwStallD), 32'd0);

        // First load after release: SUB with register operands
        rst_n = 1'b1;
        cycle();
        check_all("sub_reg");
        chk("sub_reg/srca5", bus.SrcAE, 32'd5);
        chk("sub_reg/srcb7", bus.SrcBE, 32'd7);
        chk("sub_reg/aluctl", 32'(bus.CtrlE.ALUControl), 32'd1);

        // Immediate operand selects ImmExt for SrcB, store data still rs2
        set_d(1'b1, mk_ctrl(1'b1, 2'b00, 3'b001, 1'b1), 32'd5, 32'd7, 32'h800, 5'd1, 5'd2, 5'd4);
        cycle();
        check_all("sub_imm");
        chk("sub_imm/srcb", bus.SrcBE, 32'h800);
        chk("sub_imm/wdata", bus.WriteDataE, 32'd7);

        // Forwarding priority on rs1 = x3
        set_d(1'b1, mk_ctrl(1'b1, 2'b00, 3'b000, 1'b0), 32'h11, 32'h22, 32'd0, 5'd3, 5'd6, 5'd7);
        cycle();
        set_mw(1'b1, 5'd3, 32'h10, 1'b1, 5'd3, 32'h20);
        check_all("fwd_mem");
        chk("fwd_mem/srca", bus.SrcAE, 32'h10);
        chk("fwd_mem/sel", 32'(bus.ForwardAE), 32'd2);
        set_mw(1'b1, 5'd0, 32'h10, 1'b1, 5'd3, 32'h20);
        check_all("fwd_wb");
        chk("fwd_wb/srca", bus.SrcAE, 32'h20);
        chk("fwd_wb/sel", 32'(bus.ForwardAE), 32'd1);
        set_mw(1'b1, 5'd0, 32'h10, 1'b1, 5'd0, 32'h20);
        check_all("fwd_none");
        chk("fwd_none/srca", bus.SrcAE, 32'h11);

        // Load-use: load x5 in E, consumer reads x5 as rs2
        set_d(1'b1, mk_ctrl(1'b1, 2'b01, 3'b000, 1'b1), 32'h40, 32'd0, 32'd4, 5'd2, 5'd0, 5'd5);
        cycle();
        set_d(1'b1, mk_ctrl(1'b1, 2'b00, 3'b000, 1'b0), 32'd1, 32'd2, 32'd0, 5'd1, 5'd5, 5'd8);
        check_all("lu_detect");
        chk("lu_detect/stall", 32'(bus.LwStallD), 32'd1);
        cycle();
        check_all("lu_bubble");
        chk("lu_bubble/valid", 32'(bus.ValidE), 32'd0);
        chk("lu_bubble/rd", 32'(bus.RdE), 32'd0);
        chk("lu_bubble/ctrl", 32'(bus.CtrlE), 32'd0);
        chk("lu_bubble/stall", 32'(bus.LwStallD), 32'd0);
        cycle();
        set_mw(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h55);
        check_all("lu_consume");
        chk("lu_consume/valid", 32'(bus.ValidE), 32'd1);
        chk("lu_consume/wdata", bus.WriteDataE, 32'h55);

        // Flush kills a valid instruction
        set_mw(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        set_d(1'b1, mk_ctrl(1'b1, 2'b10, 3'b011, 1'b0), 32'h9, 32'ha, 32'hb, 5'd9, 5'd10, 5'd11);
        bus.FlushE = 1'b1;
        cycle();
        bus.FlushE = 1'b0;
        check_all("flush");
        chk("flush/valid", 32'(bus.ValidE), 32'd0);

        // Hold beats flush: E keeps the instruction loaded here
        cycle();
        check_all("pre_hold");
        bus.FlushE = 1'b1;
        bus.HoldE  = 1'b1;
        set_d(1'b1, mk_ctrl(1'b0, 2'b00, 3'b010, 1'b1), 32'h1, 32'h2, 32'h3, 5'd12, 5'd13, 5'd14);
        cycle();
        check_all("hold_flush");
        chk("hold_flush/rd", 32'(bus.RdE), 32'd11);
        chk("hold_flush/valid", 32'(bus.ValidE), 32'd1);

        // Reset wins over hold
        bus.FlushE = 1'b0;
        rst_n      = 1'b0;
        cycle();
        check_all("rst_in_hold");
        chk("rst_in_hold/valid", 32'(bus.ValidE), 32'd0);
        chk("rst_in_hold/rd", 32'(bus.RdE), 32'd0);
        rst_n     = 1'b1;
        bus.HoldE = 1'b0;

        // Randomized traffic with small register indices to provoke hazards
        for (int i = 0; i < 400; i++) begin
            rand_d();
            bus.HoldE  = ($urandom_range(0, 7) == 0);
            bus.FlushE = ($urandom_range(0, 7) == 0);
            rst_n      = ($urandom_range(0, 39) != 0);
            set_mw($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
            check_all("random");
            cycle();
        end
        check_all("random_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
